multdiv_unit: RTL
=================

Name: multdiv_unit

Overview:
- Iterative signed multiply/divide responder on the execute-stage multdiv handshake.
- The pipeline pulses ctrl_MULT or ctrl_DIV with operands; this block computes over WIDTH cycles and pulses data_resultRDY.
- Sits beside the execute-stage ALU. Its result is written back to rd. The exception flag lets the pipeline redirect to the status register.

Parameters:
- WIDTH, 32, operand/result width; also the number of iteration cycles.

Ports:
- clock  input  1  master clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- data_operandA  input  WIDTH  multiplicand / dividend (signed two's complement)
- data_operandB  input  WIDTH  multiplier / divisor (signed two's complement)
- ctrl_MULT  input  1  one-cycle start pulse for multiply
- ctrl_DIV  input  1  one-cycle start pulse for divide
- data_result  output  WIDTH  product low word or quotient
- data_exception  output  1  overflow or divide-by-zero flag, valid with result
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- States:
  - IDLE: waiting for a start pulse.
  - MULT: shift-add on operand magnitudes, sign fixed at end. Radix-2 Booth is equally acceptable if results match.
  - DIV: restoring division on magnitudes.
  - DONE: result presented.
- Start (any state except during reset):
  - At the rising edge where ctrl_MULT or ctrl_DIV is high ("edge 0"), latch both operands and clear the counter.
  - Enter MULT or DIV. busy=1 from that edge.
  - Both pulses high together: MULT wins, DIV is ignored.
- Iteration: exactly one step per edge, edges 1..WIDTH. Counter is log2(WIDTH)+1 bits and counts 0..WIDTH.
- Completion:
  - At edge WIDTH+1, enter DONE: data_resultRDY=1 for exactly one cycle, busy=0. Default 33 cycles after edge 0.
  - The next edge returns to IDLE with data_resultRDY=0.
  - data_result and data_exception hold their values until the next start edge, then clear to 0.
- Multiply:
  - data_result = low WIDTH bits of the signed 2*WIDTH product.
  - data_exception=1 iff the upper WIDTH+1 bits of the product are not all equal (not representable in WIDTH signed).
- Divide:
  - Quotient truncates toward zero. Remainder is discarded.
  - Quotient sign = XOR of operand signs, applied after magnitude division.
  - Divisor==0: data_result=0, data_exception=1, same latency as a normal divide (unless the optional feature is enabled).
  - Dividend=-2^(WIDTH-1) and divisor=-1: data_result=0x80000000 (for WIDTH=32), data_exception=1.
- Start while busy: abort the current operation and restart with the new operands. No data_resultRDY is produced for the aborted operation.
- Start in the DONE cycle: accepted. The RDY pulse still shows for that cycle, and the result clears at the start edge.
- Operand inputs may change after edge 0 without affecting the operation.
- Reset mid-operation: next edge forces the reset values. No RDY pulse.

Optional Feature:
- Macro: MULTDIV_EARLY_DIV0_EN.
- Defined: a divide whose latched divisor is 0 skips iteration. Edge 1 goes straight to DONE with data_result=0, data_exception=1, data_resultRDY=1. busy is high only between edge 0 and edge 1.
- Undefined: divide-by-zero takes the full WIDTH+1 latency, as described in Behaviour.
- Multiply behaviour is identical either way.

Test Plan:
- Basic multiply: reset 2 cycles; ctrl_MULT with A=7, B=-6 -> after 33 edges data_resultRDY pulses 1 cycle, data_result=0xFFFFFFD6 (-42), exception=0, busy low at RDY.
- Multiply overflow: A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1. Also A=0x40000000, B=2 -> result=0x80000000, exception=1.
- Divide signs: A=-17, B=5 -> -3 (0xFFFFFFFD). A=17, B=-5 -> -3. A=-17, B=-5 -> 3. All with exception=0 and latency 33.
- Divide corners:
  - A=100, B=0 -> result=0, exception=1, RDY at 33 cycles (at edge 1 with MULTDIV_EARLY_DIV0_EN).
  - A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Abort/restart: ctrl_DIV (A=50, B=7), then ctrl_MULT (A=3, B=4) 10 cycles later -> exactly one RDY pulse, 33 cycles after the MULT pulse, result=12.
- Reset mid-op: ctrl_MULT (A=5, B=5), assert reset at cycle 15 for 1 cycle -> all outputs 0 and no RDY for 40 cycles. Then simultaneous ctrl_MULT and ctrl_DIV (A=6, B=3) -> result=18 (multiply wins).

Source files
------------

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide unit: shift-add multiply, restoring divide, WIDTH+1 edges per op.
// Optional `MULTDIV_EARLY_DIV0_EN: divide by zero completes on the first iteration edge.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;    // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   mag;    // multiplicand or divisor magnitude
    logic               neg;
    logic               div0;

    logic               start, finish;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_exc;

    assign start = ctrl_MULT | ctrl_DIV;
    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

`ifdef MULTDIV_EARLY_DIV0_EN
    assign finish = (cnt == CW'(WIDTH)) || (state == DIV && div0);
`else
    assign finish = (cnt == CW'(WIDTH));
`endif

    // One datapath step per edge; the same accumulator serves both operations.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
    assign div_rs   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_rs >= {1'b0, mag};
    assign div_diff = div_rs[WIDTH-1:0] - mag;

    // Sign fix-up and exception detection once the magnitudes are done.
    assign prod_s = neg ? -acc : acc;
    assign quot_s = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    always_comb begin
        fin_result = '0;
        fin_exc    = 1'b0;
        if (state == MULT) begin
            fin_result = prod_s[WIDTH-1:0];
            fin_exc    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
        end else if (div0) begin
            fin_exc    = 1'b1;
        end else begin
            fin_result = quot_s;
            // Only -2^(W-1) / -1 yields a positive quotient that does not fit.
            fin_exc    = acc[WIDTH-1] && !neg;
        end
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = ctrl_MULT ? MULT : DIV;
        end else begin
            case (state)
                MULT, DIV: if (finish) state_n = DONE;
                DONE:      state_n = IDLE;
                default:   state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            acc            <= '0;
            mag            <= '0;
            neg            <= 1'b0;
            div0           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                cnt            <= '0;
                neg            <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div0           <= (data_operandB == '0);
                mag            <= ctrl_MULT ? a_mag : b_mag;
                acc            <= {{WIDTH{1'b0}}, (ctrl_MULT ? b_mag : a_mag)};
                data_result    <= '0;
                data_exception <= 1'b0;
                data_resultRDY <= 1'b0;
                busy           <= 1'b1;
            end else begin
                case (state)
                    MULT, DIV: begin
                        if (finish) begin
                            data_result    <= fin_result;
                            data_exception <= fin_exc;
                            data_resultRDY <= 1'b1;
                            busy           <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (state == MULT)
                                acc <= {mul_sum, acc[WIDTH-1:1]};
                            else
                                acc <= {(div_ge ? div_diff : div_rs[WIDTH-1:0]),
                                        acc[WIDTH-2:0], div_ge};
                        end
                    end
                    DONE:    data_resultRDY <= 1'b0;
                    default: ;
                endcase
            end
        end
    end
endmodule
